// File: rtl/uart_pkg.sv
// Shared UART timing constants and the arbiter state encoding, also used by
// the send_ctrl-style senders that drive uart_send.
package uart_pkg;

    localparam int CYCLES_PER_BIT = 10416;
    localparam int CHAR_BITS      = 10;
    localparam int CHAR_CYCLES    = CYCLES_PER_BIT * CHAR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        WAIT = 2'b10
    } state_e;

endpackage

// File: rtl/uart_char_timer.sv
// Character-time counter: counts 0..CHAR_CYCLES-1 while en is high and pulses
// done on the terminal count, wrapping back to zero.
module uart_char_timer #(
    parameter int CHAR_CYCLES = 104160
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    output logic done
);

    localparam int CW = (CHAR_CYCLES > 1) ? $clog2(CHAR_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(CHAR_CYCLES - 1);

    logic [CW-1:0] char_cnt_q, char_cnt_d;

    assign done = en && (char_cnt_q == TERM);

    always_comb begin
        char_cnt_d = char_cnt_q;
        if (start) begin
            char_cnt_d = '0;
        end else if (en) begin
            char_cnt_d = done ? '0 : char_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_cnt_q <= '0;
        end else begin
            char_cnt_q <= char_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a single uart_send. Each byte gets one
// tx_valid pulse followed by a full character time before the next decision.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = uart_pkg::CYCLES_PER_BIT,
    parameter int CHAR_BITS      = uart_pkg::CHAR_BITS,
    parameter int LOCK_TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ack,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        owner,
    output logic        lock,
    output state_e      dbg_state
);

    localparam int CHAR_CYC = CYCLES_PER_BIT * CHAR_BITS;
    localparam int LW       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [LW-1:0] LOCK_TERM = LW'(LOCK_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [1:0]      req_ack_q, req_ack_d;
    logic            owner_q, owner_d;
    logic            lock_q, lock_d;
    logic            busy_q, busy_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            sel, sel_ok, timer_done;

    uart_char_timer #(.CHAR_CYCLES(CHAR_CYC)) u_char_timer (
        .clk   (clk),
        .rst   (rst),
        .start (state_q == SEND),
        .en    (state_q == WAIT),
        .done  (timer_done)
    );

    // Handshake: req_valid[i] holds its byte stable until a one-cycle
    // req_ack[i]; requests are only sampled in IDLE, never during SEND/WAIT.
    always_comb begin
        sel    = 1'b0;
        sel_ok = 1'b0;
        if (lock_q) begin
            sel    = owner_q;
            sel_ok = req_valid[owner_q];
        end else begin
            case (req_valid)
                2'b01:   begin sel = 1'b0;     sel_ok = 1'b1; end
                2'b10:   begin sel = 1'b1;     sel_ok = 1'b1; end
                2'b11:   begin sel = ~owner_q; sel_ok = 1'b1; end
                default: begin sel = 1'b0;     sel_ok = 1'b0; end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        req_ack_d  = 2'b00;
        owner_d    = owner_q;
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_ok) begin
                    tx_data_d  = sel ? req_data[15:8] : req_data[7:0];
                    owner_d    = sel;
                    lock_d     = ~req_last[sel];
                    lock_cnt_d = '0;
                    tx_valid_d = 1'b1;
                    req_ack_d  = sel ? 2'b10 : 2'b01;
                    state_d    = SEND;
                end else if (lock_q) begin
                    // Abandoned packet: release the lock but keep owner, so
                    // the other requester wins the next contention.
                    if (lock_cnt_q == LOCK_TERM) begin
                        lock_d     = 1'b0;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end else begin
                    lock_cnt_d = '0;
                end
            end
            SEND:    state_d = WAIT;
            WAIT:    if (timer_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || lock_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            req_ack_q  <= 2'b00;
            owner_q    <= 1'b1;
            lock_q     <= 1'b0;
            busy_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            req_ack_q  <= req_ack_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            busy_q     <= busy_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign req_ack   = req_ack_q;
    assign owner     = owner_q;
    assign lock      = lock_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with CHAR_CYCLES=40 and LOCK_TIMEOUT=100:
// directed packets per requester, expected grants queued, monitor compares pulses.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        owner;
    logic        lock;
    state_e      dbg_state;

    // expected entry: {gap[7:0], ack[1:0], data[7:0]}; gap 0 means unchecked
    logic [17:0] exp_q[$];
    logic [8:0]  src0_q[$];
    logic [8:0]  src1_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    uart_tx_arbiter #(
        .CYCLES_PER_BIT(4),
        .CHAR_BITS     (10),
        .LOCK_TIMEOUT  (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .owner     (owner),
        .lock      (lock),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester driver: retires the head byte after an ack, presents the next.
    initial begin
        logic [1:0] a;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            a = req_ack;
            @(negedge clk);
            if (a[0] && src0_q.size() > 0) void'(src0_q.pop_front());
            if (a[1] && src1_q.size() > 0) void'(src1_q.pop_front());
            req_valid[0] = (src0_q.size() > 0);
            req_valid[1] = (src1_q.size() > 0);
            {req_last[0], req_data[7:0]}  = (src0_q.size() > 0) ? src0_q[0] : 9'h0;
            {req_last[1], req_data[15:8]} = (src1_q.size() > 0) ? src1_q[0] : 9'h0;
        end
    end

    // Monitor: every tx_valid pulse must match the head of the expected queue.
    initial begin
        logic [17:0] e;
        int last_cyc;
        bit have_last;
        have_last = 0;
        last_cyc  = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                have_last = 0;
            end else if (tx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {24'h0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", {24'h0, tx_data}, {24'h0, e[7:0]});
                    check("req_ack", {30'h0, req_ack}, {30'h0, e[9:8]});
                    if (e[17:10] != 8'd0 && have_last)
                        check("pulse_gap", cyc - last_cyc, {24'h0, e[17:10]});
                end
                last_cyc  = cyc;
                have_last = 1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_valid !== 1'b1 && n < 300);
        check("pulse_seen", {31'h0, tx_valid}, 32'h1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0;
        #17;
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_req_ack", {30'h0, req_ack}, 32'h0);
        check("rst_lock", {31'h0, lock}, 32'h0);
        check("rst_owner", {31'h0, owner}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_state", {30'h0, dbg_state}, {30'h0, IDLE});

        // 1: single byte, latency, lock and busy release
        do_reset();
        src0_q.push_back({1'b1, 8'h68});
        exp_q.push_back({8'd0, 2'b01, 8'h68});
        @(negedge clk);
        check("t1_no_early_pulse", {31'h0, tx_valid}, 32'h0);
        @(negedge clk);
        check("t1_pulse", {31'h0, tx_valid}, 32'h1);
        check("t1_lock", {31'h0, lock}, 32'h0);
        repeat (40) @(negedge clk);
        check("t1_busy_hold", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("t1_busy_fall", {31'h0, busy}, 32'h0);
        wait_drain();

        // 2: both requesters with single-byte packets alternate, 42 cycles apart
        do_reset();
        for (int i = 0; i < 3; i++) begin
            src0_q.push_back({1'b1, 8'h41});
            src1_q.push_back({1'b1, 8'h42});
        end
        exp_q.push_back({8'd0, 2'b01, 8'h41});
        for (int i = 0; i < 5; i++)
            exp_q.push_back((i % 2 == 0) ? {8'd42, 2'b10, 8'h42} : {8'd42, 2'b01, 8'h41});
        wait_drain();

        // 3: multi-byte packet holds the lock against a waiting requester
        do_reset();
        src0_q.push_back({1'b0, 8'h61});
        src0_q.push_back({1'b0, 8'h62});
        src0_q.push_back({1'b1, 8'h63});
        src1_q.push_back({1'b1, 8'h5A});
        exp_q.push_back({8'd0, 2'b01, 8'h61});
        exp_q.push_back({8'd42, 2'b01, 8'h62});
        exp_q.push_back({8'd42, 2'b01, 8'h63});
        exp_q.push_back({8'd42, 2'b10, 8'h5A});
        wait_drain();

        // 4: abandoned packet, lock timeout, then requester 1 granted
        do_reset();
        src0_q.push_back({1'b0, 8'h11});
        src1_q.push_back({1'b1, 8'h22});
        exp_q.push_back({8'd0, 2'b01, 8'h11});
        exp_q.push_back({8'd142, 2'b10, 8'h22});
        wait_pulse();
        check("t4_lock_set", {31'h0, lock}, 32'h1);
        repeat (140) @(negedge clk);
        check("t4_lock_held", {31'h0, lock}, 32'h1);
        check("t4_no_ack_yet", {30'h0, req_ack}, 32'h0);
        @(negedge clk);
        check("t4_lock_released", {31'h0, lock}, 32'h0);
        check("t4_owner_kept", {31'h0, owner}, 32'h0);
        wait_drain();

        // 5: asynchronous reset during WAIT of a locked packet
        do_reset();
        src0_q.push_back({1'b0, 8'h31});
        src0_q.push_back({1'b0, 8'h32});
        exp_q.push_back({8'd0, 2'b01, 8'h31});
        wait_pulse();
        repeat (10) @(negedge clk);
        check("t5_lock_before", {31'h0, lock}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("t5_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("t5_lock", {31'h0, lock}, 32'h0);
        check("t5_tx_data", {24'h0, tx_data}, 32'h0);
        check("t5_owner", {31'h0, owner}, 32'h1);
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_state", {30'h0, dbg_state}, {30'h0, IDLE});
        do_reset();
        src0_q.push_back({1'b1, 8'h55});
        src1_q.push_back({1'b1, 8'h66});
        exp_q.push_back({8'd0, 2'b01, 8'h55});
        exp_q.push_back({8'd42, 2'b10, 8'h66});
        wait_drain();

        // 6: request rising mid-WAIT waits for the IDLE decision
        do_reset();
        src0_q.push_back({1'b1, 8'h71});
        exp_q.push_back({8'd0, 2'b01, 8'h71});
        wait_pulse();
        repeat (15) @(posedge clk);
        #1;
        src1_q.push_back({1'b1, 8'h72});
        exp_q.push_back({8'd42, 2'b10, 8'h72});
        repeat (27) @(negedge clk);
        check("t6_idle_decision", {30'h0, dbg_state}, {30'h0, IDLE});
        check("t6_no_ack_in_idle", {30'h0, req_ack}, 32'h0);
        wait_drain();

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
